// File: rtl/sha256_func_sigma1.sv
// SHA-256 upper-case Sigma1 on working variable E: ROTR6 ^ ROTR11 ^ ROTR25.
// Exposes both the combinational result and a one-cycle registered copy.
module sha256_func_sigma1 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_E,
  output logic [DATA_W-1:0] func_comb,
  output logic [DATA_W-1:0] func,
  output logic              out_valid
);

  if (DATA_W != 32) begin : g_bad_width
    $error("sha256_func_sigma1: DATA_W must be 32");
  end

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    rotr = (x >> n) | (x << (DATA_W - n));
  endfunction

  always_comb begin
    func_comb = rotr(in_E, 6) ^ rotr(in_E, 11) ^ rotr(in_E, 25);
  end

  // Valid semantics: in_valid qualifies in_E on a rising edge; out_valid is high
  // for exactly the cycle after a qualified input. No ready/backpressure exists.
  // func only loads on qualified inputs, so unqualified (possibly X) in_E is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      func      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        func <= func_comb;
      end
    end
  end

endmodule

// File: tb/tb_sha256_func_sigma1.sv
// Directed and random checks of sha256_func_sigma1 against a per-bit rotate-XOR model.
module tb_sha256_func_sigma1;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_E;
  logic [31:0] func_comb;
  logic [31:0] func;
  logic        out_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] held;

  sha256_func_sigma1 #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_E      (in_E),
    .func_comb (func_comb),
    .func      (func),
    .out_valid (out_valid)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built bit by bit from the rotate definition.
  function automatic logic [31:0] sigma1_ref(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[(i + 6) % 32] ^ x[(i + 11) % 32] ^ x[(i + 25) % 32];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic v, input logic [31:0] e);
    rst_n    = rst;
    in_valid = v;
    in_E     = e;
    #1;
  endtask

  logic [31:0] dir_in  [4] = '{32'h00000001, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};
  logic [31:0] dir_exp [4] = '{32'h04200080, 32'h02100040, 32'h00000000, 32'hFFFFFFFF};

  initial begin
    // Reset held for two edges with a qualified input present
    drive(1'b0, 1'b1, 32'h510e527f);
    check("reset_comb", func_comb, 32'h3587272b);
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_func", func, 32'h0);
      check("reset_valid", {31'b0, out_valid}, 32'h0);
      check("reset_comb_hold", func_comb, 32'h3587272b);
    end

    // Standard vector
    drive(1'b1, 1'b1, 32'h510e527f);
    check("std_comb", func_comb, 32'h3587272b);
    step();
    check("std_func", func, 32'h3587272b);
    check("std_valid", {31'b0, out_valid}, 32'h1);

    // Single-bit rotations and extremes
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, dir_in[i]);
      check("dir_comb", func_comb, dir_exp[i]);
      step();
      check("dir_func", func, dir_exp[i]);
      check("dir_valid", {31'b0, out_valid}, 32'h1);
    end

    // Valid gating
    drive(1'b1, 1'b1, 32'h510e527f);
    step();
    check("gate_load", func, 32'h3587272b);
    drive(1'b1, 1'b0, 32'h00000001);
    for (int i = 0; i < 3; i++) begin
      check("gate_comb", func_comb, 32'h04200080);
      step();
      check("gate_func", func, 32'h3587272b);
      check("gate_valid", {31'b0, out_valid}, 32'h0);
    end

    // Undefined E while unqualified must not disturb func
    drive(1'b1, 1'b0, 32'hxxxxxxxx);
    step();
    check("x_hold_func", func, 32'h3587272b);

    // Full-throughput stream
    for (int i = 0; i < 3; i++) begin
      logic [31:0] sv [3] = '{32'h510e527f, 32'h00000001, 32'hFFFFFFFF};
      logic [31:0] se [3] = '{32'h3587272b, 32'h04200080, 32'hFFFFFFFF};
      drive(1'b1, 1'b1, sv[i]);
      step();
      check("stream_func", func, se[i]);
      check("stream_valid", {31'b0, out_valid}, 32'h1);
    end

    // Reset in the middle of the stream
    drive(1'b0, 1'b1, 32'h80000000);
    step();
    check("midrst_func", func, 32'h0);
    check("midrst_valid", {31'b0, out_valid}, 32'h0);
    drive(1'b1, 1'b1, 32'h510e527f);
    step();
    check("resume_func", func, 32'h3587272b);
    check("resume_valid", {31'b0, out_valid}, 32'h1);
    drive(1'b1, 1'b1, 32'h00000001);
    step();
    check("resume_func2", func, 32'h04200080);
    held = 32'h04200080;

    // Random sweep with scoreboard
    for (int i = 0; i < 1200; i++) begin
      logic        v;
      logic [31:0] e;
      v = ($urandom_range(0, 3) != 0);
      e = $urandom();
      drive(1'b1, v, e);
      check("rand_comb", func_comb, sigma1_ref(e));
      if (v) exp_q.push_back(sigma1_ref(e));
      step();
      check("rand_valid", {31'b0, out_valid}, {31'b0, v});
      if (v && exp_q.size() > 0) held = exp_q.pop_front();
      check("rand_func", func, held);
    end
    check("queue_empty", exp_q.size(), 32'h0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
